spi_master: RTL and testbench
=============================

# spi_master

Parametrised SPI master that replaces the fixed 8-bit, single-CS SPI unit on the CPU I/O bus. It adds configurable word width, multiple chip selects, runtime clock divider and SPI mode (CPOL/CPHA), and an optional "card not responding" timeout detector. It sits between the CPU I/O registers (`start`/`cmd`/`tx`/`rx`/status) and the SD-card/flash pins, in the 50 MHz domain.

## Interface
- `DW`, default 8: transfer word width in bits, 4..32.
- `CS_N`, default 2: number of chip-select lines, 1..8.
- `INIT_CLKS`, default 80: SCLK cycles emitted by the INIT command.
- `TMO_N`, default 256: consecutive all-ones replies that raise `timeout` (only with `SPI_TIMEOUT_EN`).
- `clock  in  1`: system clock; all logic is on the rising edge.
- `reset  in  1`: asynchronous, active-high.
- `start  in  1`: one-cycle command strobe; ignored while `busy`.
- `cmd  in  2`: 0 XFER, 1 INIT, 2 CS_ON, 3 CS_OFF.
- `cs_sel  in  max(1,$clog2(CS_N))`: chip-select index used by CS_ON.
- `div  in  8`: SCLK half-period is `div+1` clocks.
- `cpol  in  1`, `cpha  in  1`: SPI mode.
- `tx  in  DW`: word to send, MSB first.
- `rx  out  DW`: last received word. Reset value 0.
- `busy  out  1`: operation in progress. Reset value 0.
- `timeout  out  1`: sticky "no response" flag. Reset value 0.
- `spi_cs  out  CS_N`: active-low chip selects. Reset value all ones.
- `spi_sclk  out  1`: registered serial clock. Reset value 0.
- `spi_mosi  out  1`: registered serial data out. Reset value 1.
- `spi_miso  in  1`: serial data in. Not synchronised; pins meet timing at 50 MHz.

## Operation
- States: IDLE, LEAD (first half-bit), TRAIL (second half-bit), DONE.
- In IDLE, `spi_sclk` follows `cpol` and `spi_mosi` is 1.
- `start` in IDLE latches `cmd`, `cs_sel`, `div`, `cpol`, `cpha` and `tx`. Input changes while `busy` have no effect.
- CS_ON: `spi_cs[cs_sel]` goes to 0 and all other lines go to 1. `cs_sel >= CS_N` drives all lines to 1. No SCLK.
- CS_OFF: all `spi_cs` lines go to 1. No SCLK. Clears the timeout counter and flag.
- XFER: clocks DW bits; `spi_cs` is unchanged, so software must issue CS_ON first.
  - CPHA=0: MOSI presents bit DW-1 on accept. MISO is sampled on the leading edge; MOSI shifts on the trailing edge.
  - CPHA=1: MOSI shifts on the leading edge; MISO is sampled on the trailing edge.
- INIT: all `spi_cs` lines go to 1, MOSI is held at 1, and `INIT_CLKS` SCLK cycles are emitted. Clears the timeout counter and flag.
- Leading edge: SCLK moves away from `cpol`. Trailing edge: SCLK returns to `cpol`.
- Half-period counter: 8 bits; it reloads `div` and reaches the next edge on 0. Bit counter: `$clog2(INIT_CLKS+1)` bits, wide enough for both DW and `INIT_CLKS`.
- `rx` updates only in DONE of an XFER and holds otherwise.
- Reset mid-operation: return to IDLE immediately; all outputs take their reset values; the partial `rx` is discarded.

## Timing
- `start` accepted at edge t: `busy` is 1 from t+1.
- XFER completes in `DW*2*(div+1)` clocks of LEAD/TRAIL plus one DONE clock. `busy` falls and `rx` is valid in the same cycle.
- The next `start` is accepted in the cycle `busy` is 0, giving back-to-back transfers with one idle clock.
- CS_ON and CS_OFF: `spi_cs` changes at t+1. `busy` is high for exactly one cycle (DONE).
- INIT: `INIT_CLKS*2*(div+1)+1` busy cycles.
- `start` arriving in the same cycle as DONE is ignored.

## Configuration
- `SPI_TIMEOUT_EN` defined: adds a `$clog2(TMO_N+1)`-bit counter of consecutive XFERs with `rx` all ones.
  - `timeout` sets when the counter reaches `TMO_N`; the counter saturates there.
  - A non-all-ones `rx`, INIT, CS_OFF or reset clears both the counter and `timeout`.
- `SPI_TIMEOUT_EN` undefined: the counter is absent and `timeout` is tied to 0.

## Structure
- Package `spi_pkg`: command codes (`SPI_XFER`, `SPI_INIT`, `SPI_CS_ON`, `SPI_CS_OFF`) and the state enum.
- Sub-module `spi_clkgen`: half-period divider producing one-clock `lead`/`trail` strobes and registered SCLK from `div`/`cpol`/run. The shift/FSM logic stays in `spi_master`.

## Test plan
- Reset asserted mid-XFER with `div=3` -> next cycle `busy=0`, `spi_cs=2'b11`, `spi_sclk=0`, `spi_mosi=1`, `rx` unchanged.
- CS_ON `cs_sel=1`, then XFER `tx=8'hA5`, mode 0, `div=0`, MISO loopback -> `spi_cs=2'b01`, 16 busy LEAD/TRAIL clocks plus DONE, `rx=8'hA5`, MOSI bits 1,0,1,0,0,1,0,1.
- XFER in mode 3 (`cpol=1`, `cpha=1`), MISO driven with 8'h3C -> SCLK idles high, MISO sampled on rising edges, `rx=8'h3C`.
- INIT with `div=1` -> `spi_cs` all 1, MOSI 1, exactly 80 SCLK pulses, `busy` high for 321 cycles.
- `SPI_TIMEOUT_EN`, `TMO_N=4`, MISO held 1 -> `timeout=1` after the 4th XFER's DONE; one XFER returning 8'h00 -> `timeout=0`.
- `start` pulsed while `busy`, and `start` in the DONE cycle -> both ignored; `rx`, `spi_cs` and the transfer count unaffected.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - command codes and FSM state encoding shared by the SPI master
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_XFER   = 2'd0,
    SPI_INIT   = 2'd1,
    SPI_CS_ON  = 2'd2,
    SPI_CS_OFF = 2'd3
  } spi_cmd_e;

  // LEAD is the first half-bit (ends with the leading SCLK edge),
  // TRAIL the second half-bit (ends with the trailing SCLK edge).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_TRAIL = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SPI half-period divider with lead/trail strobes and registered SCLK
//
// Ports:
//   clock, reset    : system clock, asynchronous active-high reset
//   run             : high while the master is in a LEAD or TRAIL half-bit
//   lead_phase      : high in LEAD, low in TRAIL (selects which strobe fires)
//   pol             : SCLK idle level (CPOL) to follow / return to
//   div             : half-period reload value; half-bit lasts div+1 clocks
//   lead, trail     : one-clock strobes in the last clock of each half-bit
//   spi_sclk        : registered serial clock
module spi_clkgen (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       lead_phase,
  input  logic       pol,
  input  logic [7:0] div,
  output logic       lead,
  output logic       trail,
  output logic       spi_sclk
);

  logic [7:0] cnt;
  logic       edge_hit;

  assign edge_hit = run && (cnt == 8'd0);
  assign lead     = edge_hit && lead_phase;
  assign trail    = edge_hit && !lead_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= 8'd0;
      spi_sclk <= 1'b0;
    end else begin
      // Preloading while stopped means the first half-bit is a full div+1 clocks.
      if (!run || edge_hit) cnt <= div;
      else                  cnt <= cnt - 8'd1;

      if (!run)       spi_sclk <= pol;
      else if (lead)  spi_sclk <= ~pol;
      else if (trail) spi_sclk <= pol;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - parametrised SPI master with CS control, INIT clocks and optional timeout
//
// Optional feature: define SPI_TIMEOUT_EN to build the "card not responding" detector.
//
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   start, cmd          : one-cycle command strobe and command code (XFER/INIT/CS_ON/CS_OFF)
//   cs_sel              : chip-select index for CS_ON
//   div                 : SCLK half-period is div+1 clocks
//   cpol, cpha          : SPI mode
//   tx / rx             : word to send (MSB first) / last received word
//   busy                : operation in progress
//   timeout             : sticky no-response flag
//   spi_cs              : active-low chip selects
//   spi_sclk, spi_mosi  : registered serial clock and data out
//   spi_miso            : serial data in
module spi_master
  import spi_pkg::*;
#(
  parameter int DW        = 8,
  parameter int CS_N      = 2,
  parameter int INIT_CLKS = 80,
  parameter int TMO_N     = 256
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [1:0]                                cmd,
  input  logic [((CS_N > 1) ? $clog2(CS_N) : 1)-1:0] cs_sel,
  input  logic [7:0]                                div,
  input  logic                                      cpol,
  input  logic                                      cpha,
  input  logic [DW-1:0]                             tx,
  output logic [DW-1:0]                             rx,
  output logic                                      busy,
  output logic                                      timeout,
  output logic [CS_N-1:0]                           spi_cs,
  output logic                                      spi_sclk,
  output logic                                      spi_mosi,
  input  logic                                      spi_miso
);

  // One counter serves both the data bits and the INIT clock burst.
  localparam int BW = (INIT_CLKS > DW) ? $clog2(INIT_CLKS + 1) : $clog2(DW + 1);

  spi_state_e    state;
  spi_cmd_e      cmd_q;
  logic [7:0]    div_q;
  logic          cpol_q;
  logic          cpha_q;
  logic [DW-1:0] tx_sreg;
  logic [DW-1:0] rx_sreg;
  logic [BW-1:0] bit_cnt;
  logic [CS_N-1:0] cs_on_n;

  logic       lead, trail;
  logic       run;
  logic       pol_sel;
  logic [7:0] div_sel;
  logic       is_xfer;

  assign run     = (state == ST_LEAD) || (state == ST_TRAIL);
  assign is_xfer = (cmd_q == SPI_XFER);
  // In IDLE the live inputs drive SCLK idle level and counter preload, so the
  // first half-bit after accept already uses the new settings.
  assign pol_sel = (state == ST_IDLE) ? cpol : cpol_q;
  assign div_sel = (state == ST_IDLE) ? div  : div_q;

  always_comb begin
    cs_on_n = '1;
    for (int i = 0; i < CS_N; i++) begin
      if (int'(cs_sel) == i) cs_on_n[i] = 1'b0;
    end
  end

  spi_clkgen u_clkgen (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .lead_phase (state == ST_LEAD),
    .pol        (pol_sel),
    .div        (div_sel),
    .lead       (lead),
    .trail      (trail),
    .spi_sclk   (spi_sclk)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_q    <= SPI_XFER;
      div_q    <= 8'd0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      tx_sreg  <= '1;
      rx_sreg  <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      busy     <= 1'b0;
      spi_cs   <= '1;
      spi_mosi <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          spi_mosi <= 1'b1;
          if (start) begin
            cmd_q  <= spi_cmd_e'(cmd);
            div_q  <= div;
            cpol_q <= cpol;
            cpha_q <= cpha;
            busy   <= 1'b1;
            case (spi_cmd_e'(cmd))
              SPI_XFER: begin
                state   <= ST_LEAD;
                bit_cnt <= BW'(DW - 1);
                rx_sreg <= '0;
                // CPHA=0 must have the MSB on the wire before the first edge.
                if (!cpha) begin
                  spi_mosi <= tx[DW-1];
                  tx_sreg  <= {tx[DW-2:0], 1'b1};
                end else begin
                  tx_sreg  <= tx;
                end
              end
              SPI_INIT: begin
                state   <= ST_LEAD;
                bit_cnt <= BW'(INIT_CLKS - 1);
                tx_sreg <= '1;
                spi_cs  <= '1;
              end
              SPI_CS_ON: begin
                state  <= ST_DONE;
                spi_cs <= cs_on_n;
              end
              default: begin
                state  <= ST_DONE;
                spi_cs <= '1;
              end
            endcase
          end
        end

        ST_LEAD: begin
          if (lead) begin
            if (is_xfer && !cpha_q) rx_sreg <= {rx_sreg[DW-2:0], spi_miso};
            if (is_xfer && cpha_q) begin
              spi_mosi <= tx_sreg[DW-1];
              tx_sreg  <= {tx_sreg[DW-2:0], 1'b1};
            end
            state <= ST_TRAIL;
          end
        end

        ST_TRAIL: begin
          if (trail) begin
            if (is_xfer && cpha_q) rx_sreg <= {rx_sreg[DW-2:0], spi_miso};
            if (is_xfer && !cpha_q) begin
              spi_mosi <= tx_sreg[DW-1];
              tx_sreg  <= {tx_sreg[DW-2:0], 1'b1};
            end
            if (bit_cnt == '0) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              state   <= ST_LEAD;
            end
          end
        end

        default: begin
          busy     <= 1'b0;
          spi_mosi <= 1'b1;
          state    <= ST_IDLE;
          if (is_xfer) rx <= rx_sreg;
        end
      endcase
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TMO_N + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr;
  logic          xfer_done;

  assign tmo_clr   = (state == ST_IDLE) && start &&
                     ((spi_cmd_e'(cmd) == SPI_INIT) || (spi_cmd_e'(cmd) == SPI_CS_OFF));
  assign xfer_done = (state == ST_DONE) && is_xfer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (xfer_done) begin
      if (&rx_sreg) begin
        // Saturate at TMO_N; the flag rises on the reply that reaches it.
        if (tmo_cnt != TW'(TMO_N)) tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt >= TW'(TMO_N - 1)) timeout <= 1'b1;
      end else begin
        tmo_cnt <= '0;
        timeout <= 1'b0;
      end
    end
  end
`else
  // Detector not built: flag is constant low (TMO_N is never negative).
  assign timeout = (TMO_N < 0);
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with SPI slave model and scoreboard
module tb_spi_master;
  import spi_pkg::*;

  localparam int TMO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [0:0] cs_sel = 1'b0;
  logic [7:0] div = 8'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx = 8'd0;
  logic [7:0] rx;
  logic       busy;
  logic       timeout;
  logic [1:0] spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  int total = 0;
  int bad   = 0;

  spi_master #(.DW(8), .CS_N(2), .INIT_CLKS(80), .TMO_N(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cmd      (cmd),
    .cs_sel   (cs_sel),
    .div      (div),
    .cpol     (cpol),
    .cpha     (cpha),
    .tx       (tx),
    .rx       (rx),
    .busy     (busy),
    .timeout  (timeout),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clock = ~clock;

  // Slave model: shifts its reply out and captures MOSI according to the mode.
  logic       s_on = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_loop = 1'b0;
  logic       s_miso_bit = 1'b1;
  logic [7:0] s_miso_sreg = 8'd0;
  logic [7:0] s_cap = 8'd0;
  int         pulses = 0;
  int         mosi_low = 0;
  int         ops = 0;

  assign spi_miso = s_loop ? spi_mosi : s_miso_bit;

  always @(spi_sclk) begin
    if (s_on && busy) begin
      if (spi_sclk != s_cpol) begin
        pulses = pulses + 1;
        if (!s_cpha) s_cap = {s_cap[6:0], spi_mosi};
        else begin
          s_miso_bit  = s_miso_sreg[7];
          s_miso_sreg = {s_miso_sreg[6:0], 1'b0};
        end
      end else begin
        if (s_cpha) s_cap = {s_cap[6:0], spi_mosi};
        else begin
          s_miso_bit  = s_miso_sreg[7];
          s_miso_sreg = {s_miso_sreg[6:0], 1'b0};
        end
      end
    end
  end

  always @(negedge clock) if (busy && !spi_mosi) mosi_low = mosi_low + 1;
  always @(posedge busy) ops = ops + 1;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] miso;
    logic       loop;
    logic [7:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic s, input logic [7:0] d,
                       input logic p, input logic h, input logic [7:0] t);
    @(negedge clock);
    cmd = c; cs_sel = s; div = d; cpol = p; cpha = h; tx = t;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    @(negedge clock);
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clock);
    end
    if (cyc >= 20000) check("busy_bound", 32'(cyc), 32'd0);
  endtask

  task automatic start_xfer(input vec_t v);
    s_on = 1'b0; s_cpol = v.cpol; s_cpha = v.cpha; s_loop = v.loop;
    s_cap = 8'd0; pulses = 0;
    if (!v.cpha) begin
      s_miso_bit = v.miso[7]; s_miso_sreg = {v.miso[6:0], 1'b0};
    end else begin
      s_miso_bit = 1'b1;      s_miso_sreg = v.miso;
    end
    s_on = 1'b1;
    exp_q.push_back('{rx: v.exp_rx, mosi: v.tx});
    issue(SPI_XFER, 1'b0, v.div, v.cpol, v.cpha, v.tx);
  endtask

  task automatic check_result(input vec_t v);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("xfer_rx", 32'(rx), 32'(e.rx));
      check("xfer_mosi", 32'(s_cap), 32'(e.mosi));
      check("xfer_pulses", 32'(pulses), 32'd8);
      check("sclk_idle", 32'(spi_sclk), 32'(v.cpol));
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc;
    start_xfer(v);
    wait_idle(cyc);
    check("xfer_cycles", 32'(cyc), 32'(8 * 2 * (int'(v.div) + 1) + 1));
    check_result(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   cyc;
    int   ops0;

    //            cpol  cpha  div    tx     miso   loop  exp_rx
    vecs[0] = '{1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'd0, 8'h5A, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 8'd2, 8'hF0, 8'h81, 1'b0, 8'h81};
    vecs[3] = '{1'b1, 1'b0, 8'd1, 8'h0F, 8'h7E, 1'b0, 8'h7E};
    vecs[4] = '{1'b0, 1'b0, 8'd4, 8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[5] = '{1'b1, 1'b1, 8'd0, 8'hC3, 8'h00, 1'b1, 8'hC3};

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(spi_cs), 32'd3);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd1);
    check("rst_rx", 32'(rx), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a transfer: CS active, SCLK high, MOSI low.
    issue(SPI_CS_ON, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    wait_idle(cyc);
    check("cs_on0", 32'(spi_cs), 32'd2);
    s_on = 1'b0; s_loop = 1'b0; s_miso_bit = 1'b1;
    issue(SPI_XFER, 1'b0, 8'd3, 1'b0, 1'b0, 8'h00);
    cyc = 0;
    while (!spi_sclk && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cs", 32'(spi_cs), 32'd3);
    check("mid_rst_sclk", 32'(spi_sclk), 32'd0);
    check("mid_rst_mosi", 32'(spi_mosi), 32'd1);
    check("mid_rst_rx", 32'(rx), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // CS_ON select 1: one busy cycle, spi_cs = 01.
    issue(SPI_CS_ON, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
    wait_idle(cyc);
    check("cs_on_cycles", 32'(cyc), 32'd1);
    check("cs_on1", 32'(spi_cs), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i]);
      check("xfer_cs_held", 32'(spi_cs), 32'd1);
    end

    // INIT with div=1: 80 pulses, MOSI high, CS released, 321 busy cycles.
    s_on = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0; s_loop = 1'b0;
    pulses = 0; mosi_low = 0;
    issue(SPI_INIT, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00);
    wait_idle(cyc);
    check("init_cycles", 32'(cyc), 32'd321);
    check("init_pulses", 32'(pulses), 32'd80);
    check("init_mosi_low", 32'(mosi_low), 32'd0);
    check("init_cs", 32'(spi_cs), 32'd3);
    check("init_rx_hold", 32'(rx), 32'hC3);

    // start while busy and start in the DONE cycle are both ignored.
    issue(SPI_CS_ON, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
    wait_idle(cyc);
    ops0 = ops;
    v = '{1'b0, 1'b0, 8'd1, 8'h96, 8'h69, 1'b0, 8'h69};
    start_xfer(v);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (k == 33) check("done_cycle_busy", 32'(busy), 32'd1);
      if (k == 5 || k == 33) begin
        cmd = SPI_CS_OFF; tx = 8'h00; div = 8'd0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
      end
    end
    @(negedge clock);
    check("ign_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("ign_busy_late", 32'(busy), 32'd0);
    check("ign_cs", 32'(spi_cs), 32'd1);
    check("ign_ops", 32'(ops - ops0), 32'd1);
    check_result(v);

    // Timeout: consecutive all-ones replies, then a non-all-ones reply.
    issue(SPI_CS_OFF, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    wait_idle(cyc);
    check("cs_off", 32'(spi_cs), 32'd3);
    check("cs_off_tmo", 32'(timeout), 32'd0);
    issue(SPI_CS_ON, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    wait_idle(cyc);
    for (int i = 0; i < TMO; i++) begin
      run_xfer('{1'b0, 1'b0, 8'd0, 8'h11, 8'hFF, 1'b0, 8'hFF});
`ifdef SPI_TIMEOUT_EN
      check("tmo_ramp", 32'(timeout), 32'(i == TMO - 1));
`else
      check("tmo_off", 32'(timeout), 32'd0);
`endif
    end
    run_xfer('{1'b0, 1'b0, 8'd0, 8'h22, 8'h00, 1'b0, 8'h00});
    check("tmo_clear", 32'(timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
